// File: rtl/memory_write_scheduler_if.sv
// Request bundle between the write requesters and memory_write_scheduler.
// Each requester owns one bit of valid/ready and one packed slice of addr/data.
interface memory_write_scheduler_if #(
   parameter int NUM_WRITERS = 2,
   parameter int ADDR_WIDTH  = 9,
   parameter int DATA_WIDTH  = 32
);
   logic [NUM_WRITERS-1:0]            req_valid;
   logic [NUM_WRITERS*ADDR_WIDTH-1:0] req_addr;
   logic [NUM_WRITERS*DATA_WIDTH-1:0] req_data;
   logic [NUM_WRITERS-1:0]            req_ready;

   modport master (output req_valid, req_addr, req_data, input req_ready);
   modport slave  (input req_valid, req_addr, req_data, output req_ready);
endinterface

// File: rtl/memory_write_scheduler.sv
// Flushes the RAM bypass after reset, sweeps every address with INIT_VALUE, then
// round-robin arbitrates the requesters onto the single registered write port.
module memory_write_scheduler #(
   parameter int                    DATA_WIDTH       = 32,
   parameter int                    ADDR_WIDTH       = 9,
   parameter int                    DEPTH            = 2**ADDR_WIDTH,
   parameter int                    NUM_WRITERS      = 2,
   parameter int                    NUM_BYPASS_SLOTS = 1,
   parameter logic [DATA_WIDTH-1:0] INIT_VALUE       = '0
) (
   input  logic                     clk,
   input  logic                     rst_n,
   memory_write_scheduler_if.slave  req,
   output logic                     wren_out,
   output logic [ADDR_WIDTH-1:0]    write_addr_out,
   output logic [DATA_WIDTH-1:0]    write_data_out,
   output logic                     init_done,
   output logic                     addr_error
);

   localparam int FW = (NUM_BYPASS_SLOTS > 0) ? $clog2(NUM_BYPASS_SLOTS + 1) : 1;
   localparam int PW = (NUM_WRITERS > 1) ? $clog2(NUM_WRITERS) : 1;
   localparam logic [FW-1:0]         FLUSH_LAST = FW'((NUM_BYPASS_SLOTS > 0) ? NUM_BYPASS_SLOTS - 1 : 0);
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(DEPTH - 1);
   localparam logic [ADDR_WIDTH:0]   DEPTH_W    = (ADDR_WIDTH + 1)'(DEPTH);
   localparam logic [PW-1:0]         LAST_PTR   = PW'(NUM_WRITERS - 1);

   typedef enum logic [1:0] {FLUSH, INIT, RUN} state_t;

   // With no bypass slots there is nothing to flush, so reset lands straight in INIT.
   localparam state_t RESET_STATE = (NUM_BYPASS_SLOTS == 0) ? INIT : FLUSH;

   state_t                  state, state_next;
   logic [FW-1:0]           flush_cnt;
   logic [ADDR_WIDTH-1:0]   init_addr;
   logic [PW-1:0]           ptr;

   logic [NUM_WRITERS-1:0]  grant;
   logic [PW-1:0]           gidx;
   logic                    found;
   logic [ADDR_WIDTH-1:0]   sel_addr;
   logic [DATA_WIDTH-1:0]   sel_data;

   logic                    wr_en;
   logic [ADDR_WIDTH-1:0]   wr_addr;
   logic [DATA_WIDTH-1:0]   wr_data;
   logic                    xfer;
   logic                    bad_addr;

   // Round-robin pick: first scan from the pointer upward, then wrap below it.
   always_comb begin
      // NOTE: every variable gets a default before any branch so no latch is inferred.
      grant    = '0;
      gidx     = '0;
      found    = 1'b0;
      sel_addr = '0;
      sel_data = '0;
      for (int i = 0; i < NUM_WRITERS; i++) begin
         if (!found && i >= int'(ptr) && req.req_valid[i]) begin
            grant[i] = 1'b1;
            gidx     = PW'(i);
            found    = 1'b1;
            sel_addr = req.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            sel_data = req.req_data[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
      for (int i = 0; i < NUM_WRITERS; i++) begin
         if (!found && i < int'(ptr) && req.req_valid[i]) begin
            grant[i] = 1'b1;
            gidx     = PW'(i);
            found    = 1'b1;
            sel_addr = req.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            sel_data = req.req_data[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   always_comb begin
      state_next    = state;
      req.req_ready = '0;
      wr_en         = 1'b0;
      wr_addr       = write_addr_out;
      wr_data       = write_data_out;
      xfer          = 1'b0;
      bad_addr      = 1'b0;
      case (state)
         FLUSH: begin
            if (flush_cnt == FLUSH_LAST) state_next = INIT;
         end
         INIT: begin
            wr_en   = 1'b1;
            wr_addr = init_addr;
            wr_data = INIT_VALUE;
            if (init_addr == LAST_ADDR) state_next = RUN;
         end
         RUN: begin
            req.req_ready = grant;
            xfer          = found;
            if (found) begin
               // Out-of-range requests are still consumed; only the RAM write is dropped.
               if ({1'b0, sel_addr} < DEPTH_W) begin
                  wr_en   = 1'b1;
                  wr_addr = sel_addr;
                  wr_data = sel_data;
               end else begin
                  bad_addr = 1'b1;
               end
            end
         end
         default: state_next = RESET_STATE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= RESET_STATE;
      else        state <= state_next;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flush_cnt      <= '0;
         init_addr      <= '0;
         ptr            <= '0;
         wren_out       <= 1'b0;
         write_addr_out <= '0;
         write_data_out <= '0;
         init_done      <= 1'b0;
         addr_error     <= 1'b0;
      end else begin
         // NOTE: registers update with <= so every read in this block sees pre-edge values.
         if (state == FLUSH) flush_cnt <= flush_cnt + 1'b1;
         if (state == INIT && init_addr != LAST_ADDR) init_addr <= init_addr + 1'b1;
         if (xfer) ptr <= (gidx == LAST_PTR) ? '0 : gidx + 1'b1;
         wren_out <= wr_en;
         if (wr_en) begin
            write_addr_out <= wr_addr;
            write_data_out <= wr_data;
         end
         init_done  <= (state == RUN);
         addr_error <= addr_error | bad_addr;
      end
   end

endmodule

// File: tb/tb_memory_write_scheduler.sv
// Self-checking bench for memory_write_scheduler: directed scenarios plus a random
// phase, all compared against a requester-level round-robin model.
module tb_memory_write_scheduler;

   localparam int DW    = 8;
   localparam int AW    = 3;
   localparam int DEPTH = 6;
   localparam int NW    = 3;
   localparam int NBS   = 2;
   localparam logic [DW-1:0] INIT_V = 8'hA5;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          wren;
   logic [AW-1:0] waddr;
   logic [DW-1:0] wdata;
   logic          init_done;
   logic          addr_error;

   always #5 clk = ~clk;

   memory_write_scheduler_if #(.NUM_WRITERS(NW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   memory_write_scheduler #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .NUM_WRITERS(NW),
      .NUM_BYPASS_SLOTS(NBS), .INIT_VALUE(INIT_V)
   ) dut (
      .clk(clk), .rst_n(rst_n), .req(bus.slave),
      .wren_out(wren), .write_addr_out(waddr), .write_data_out(wdata),
      .init_done(init_done), .addr_error(addr_error)
   );

   int checks = 0;
   int errors = 0;

   // Requester-side view: pending flag, address and data per writer.
   bit            v [NW];
   logic [AW-1:0] a [NW];
   logic [DW-1:0] d [NW];

   // Model state: next writer to favour, and whether a bad address was ever accepted.
   int m_ptr;
   bit m_err;

   task automatic drive();
      for (int i = 0; i < NW; i++) begin
         bus.req_valid[i]           = v[i];
         bus.req_addr[i*AW +: AW]   = a[i];
         bus.req_data[i*DW +: DW]   = d[i];
      end
      #1;
   endtask

   task automatic clear_reqs();
      for (int i = 0; i < NW; i++) begin
         v[i] = 1'b0;
         a[i] = '0;
         d[i] = '0;
      end
   endtask

   function automatic int model_grant();
      for (int k = 0; k < NW; k++) begin
         int idx;
         idx = (m_ptr + k) % NW;
         if (v[idx]) return idx;
      end
      return -1;
   endfunction

   // One RUN cycle: check the grant, let the edge happen, check the resulting write.
   task automatic run_cycle(input string tag, output int g);
      logic [NW-1:0] exp_ready;
      bit            exp_wren;
      g = model_grant();
      exp_ready = '0;
      if (g >= 0) exp_ready[g] = 1'b1;
      checks++;
      if (bus.req_ready !== exp_ready) begin
         errors++;
         $display("FAIL %s ready: got %b want %b", tag, bus.req_ready, exp_ready);
      end
      exp_wren = (g >= 0) && (int'(a[g]) < DEPTH);
      if (g >= 0) begin
         if (int'(a[g]) >= DEPTH) m_err = 1'b1;
         m_ptr = (g + 1) % NW;
      end
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (wren !== exp_wren) begin
         errors++;
         $display("FAIL %s wren: got %b want %b", tag, wren, exp_wren);
      end
      if (exp_wren) begin
         checks++;
         if (waddr !== a[g] || wdata !== d[g]) begin
            errors++;
            $display("FAIL %s write: got %0d/%h want %0d/%h", tag, waddr, wdata, a[g], d[g]);
         end
      end
      checks++;
      if (addr_error !== m_err) begin
         errors++;
         $display("FAIL %s addr_error: got %b want %b", tag, addr_error, m_err);
      end
      if (g >= 0) v[g] = 1'b0;
   endtask

   // Release reset (caller is at a falling edge) and check flush, sweep and first RUN cycle.
   task automatic check_sweep(input bit early, input int stop_k);
      logic [NW-1:0] er;
      bit            ew;
      clear_reqs();
      if (early) begin
         v[0] = 1'b1;
         a[0] = 3'd5;
         d[0] = 8'h55;
      end
      m_ptr = 0;
      m_err = 1'b0;
      rst_n = 1'b1;
      drive();
      for (int k = 1; k <= stop_k; k++) begin
         er = '0;
         er[0] = early && v[0] && (k - 1 >= NBS + DEPTH);
         checks++;
         if (bus.req_ready !== er) begin
            errors++;
            $display("FAIL sweep ready cycle %0d: got %b want %b", k, bus.req_ready, er);
         end
         @(posedge clk);
         @(negedge clk);
         if (k <= NBS)               ew = 1'b0;
         else if (k <= NBS + DEPTH)  ew = 1'b1;
         else                        ew = early;
         checks++;
         if (wren !== ew) begin
            errors++;
            $display("FAIL sweep wren cycle %0d: got %b want %b", k, wren, ew);
         end
         if (ew && k <= NBS + DEPTH) begin
            checks++;
            if (waddr !== AW'(k - NBS - 1) || wdata !== INIT_V) begin
               errors++;
               $display("FAIL sweep write cycle %0d: got %0d/%h want %0d/%h",
                        k, waddr, wdata, k - NBS - 1, INIT_V);
            end
         end else if (ew) begin
            checks++;
            if (waddr !== 3'd5 || wdata !== 8'h55) begin
               errors++;
               $display("FAIL early write: got %0d/%h want 5/55", waddr, wdata);
            end
         end
         checks++;
         if (init_done !== (k >= NBS + DEPTH + 1)) begin
            errors++;
            $display("FAIL sweep init_done cycle %0d: got %b want %b", k, init_done, k >= NBS + DEPTH + 1);
         end
         if (early && k == NBS + DEPTH + 1) begin
            v[0] = 1'b0;
            m_ptr = 1;
            drive();
         end
      end
   endtask

   task automatic test_reset();
      for (int i = 0; i < NW; i++) begin
         v[i] = 1'b1;
         a[i] = AW'(i + 1);
         d[i] = DW'(8'h30 + i);
      end
      drive();
      checks++;
      if (wren !== 1'b0 || waddr !== '0 || wdata !== '0 || init_done !== 1'b0 ||
          addr_error !== 1'b0 || bus.req_ready !== '0) begin
         errors++;
         $display("FAIL reset values: got wren=%b addr=%0d data=%h done=%b err=%b ready=%b want all 0",
                  wren, waddr, wdata, init_done, addr_error, bus.req_ready);
      end
      clear_reqs();
      drive();
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (wren !== 1'b0 || init_done !== 1'b0) begin
         errors++;
         $display("FAIL held reset: got wren=%b done=%b want 0/0", wren, init_done);
      end
   endtask

   task automatic test_init_sweep();
      check_sweep(1'b0, NBS + DEPTH + 1);
   endtask

   task automatic test_alternate();
      logic [NW-1:0] want;
      int g;
      clear_reqs();
      v[0] = 1'b1; a[0] = 3'd1; d[0] = 8'h11;
      v[1] = 1'b1; a[1] = 3'd2; d[1] = 8'h22;
      drive();
      for (int n = 0; n < 8; n++) begin
         want = (n % 2 == 0) ? 3'b001 : 3'b010;
         checks++;
         if (bus.req_ready !== want) begin
            errors++;
            $display("FAIL alternate grant %0d: got %b want %b", n, bus.req_ready, want);
         end
         run_cycle("alternate", g);
         if (g >= 0) v[g] = 1'b1;
         drive();
      end
      clear_reqs();
      drive();
   endtask

   task automatic test_stream_w1();
      int g;
      clear_reqs();
      v[1] = 1'b1;
      a[1] = 3'd0;
      d[1] = DW'($urandom);
      drive();
      for (int n = 0; n < 4; n++) begin
         run_cycle("stream_w1", g);
         if (n < 3) begin
            v[1] = 1'b1;
            a[1] = AW'(n + 1);
            d[1] = DW'($urandom);
         end
         drive();
      end
   endtask

   task automatic test_addr_error();
      int g;
      clear_reqs();
      checks++;
      if (addr_error !== 1'b0) begin
         errors++;
         $display("FAIL addr_error before bad write: got %b want 0", addr_error);
      end
      v[0] = 1'b1; a[0] = 3'd7; d[0] = 8'h77;
      drive();
      run_cycle("bad_addr", g);
      checks++;
      if (wren !== 1'b0 || addr_error !== 1'b1) begin
         errors++;
         $display("FAIL bad_addr effect: got wren=%b err=%b want 0/1", wren, addr_error);
      end
      v[0] = 1'b1; a[0] = 3'd3; d[0] = 8'h33;
      drive();
      run_cycle("good_after_bad", g);
      drive();
      for (int n = 0; n < 3; n++) run_cycle("error_sticky", g);
   endtask

   task automatic test_random();
      int g;
      for (int n = 0; n < 300; n++) begin
         for (int i = 0; i < NW; i++) begin
            if (!v[i] && $urandom_range(1, 0) == 1) begin
               v[i] = 1'b1;
               a[i] = AW'($urandom_range(7, 0));
               d[i] = DW'($urandom);
            end
         end
         drive();
         run_cycle("random", g);
      end
      clear_reqs();
      drive();
   endtask

   task automatic test_reset_mid_init();
      rst_n = 1'b0;
      clear_reqs();
      drive();
      checks++;
      if (addr_error !== 1'b0 || init_done !== 1'b0 || wren !== 1'b0) begin
         errors++;
         $display("FAIL reset clears sticky: got err=%b done=%b wren=%b want 0/0/0",
                  addr_error, init_done, wren);
      end
      @(negedge clk);
      check_sweep(1'b0, NBS + 5);
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (wren !== 1'b0 || waddr !== '0 || wdata !== '0 || init_done !== 1'b0 || addr_error !== 1'b0) begin
         errors++;
         $display("FAIL async reset mid-init: got wren=%b addr=%0d data=%h done=%b err=%b want all 0",
                  wren, waddr, wdata, init_done, addr_error);
      end
      @(negedge clk);
      check_sweep(1'b1, NBS + DEPTH + 1);
   endtask

   initial begin
      clear_reqs();
      m_ptr = 0;
      m_err = 1'b0;
      test_reset();
      test_init_sweep();
      test_alternate();
      test_stream_w1();
      test_addr_error();
      test_random();
      test_reset_mid_init();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/memory_write_scheduler.md
# memory_write_scheduler

Sequencer and arbiter for the single write port of a Kanagawa RAM instance that has memory bypass logic in front of its read port. After reset it holds the write port idle long enough to flush the bypass slots, then sweeps every address with an initial value. Once initialised, it round-robin arbitrates up to NUM_WRITERS independent write requesters onto the one registered write port (wren/addr/data) shared by the RAM and its bypass logic.

## Interface

Parameters:

- DATA_WIDTH, 32: width of each write data word.
- ADDR_WIDTH, 9: width of each write address.
- DEPTH, 2**ADDR_WIDTH: number of valid addresses, 1..2**ADDR_WIDTH.
- NUM_WRITERS, 2: number of requesters, 1..16.
- NUM_BYPASS_SLOTS, 1: bypass depth of the downstream RAM, ≥0; sets the flush length.
- INIT_VALUE, '0: DATA_WIDTH-bit value written to every address during init.

Ports:

- clk  in  1  clock; all logic is on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  NUM_WRITERS  per-requester write request.
- req_addr  in  NUM_WRITERS*ADDR_WIDTH  addresses; requester i occupies bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_data  in  NUM_WRITERS*DATA_WIDTH  data, packed in the same way.
- req_ready  out  NUM_WRITERS  one-hot grant, combinational from state and req_valid.
- wren_out  out  1  registered write enable to the RAM and bypass.
- write_addr_out  out  ADDR_WIDTH  registered write address.
- write_data_out  out  DATA_WIDTH  registered write data.
- init_done  out  1  high once the RUN state is reached.
- addr_error  out  1  sticky: set when an out-of-range write is accepted.

## Operation

- The state machine has three states: FLUSH, INIT and RUN. Reset forces FLUSH.
- FLUSH
  - wren_out=0 for exactly NUM_BYPASS_SLOTS cycles; the counter is $clog2(NUM_BYPASS_SLOTS+1) bits.
  - If NUM_BYPASS_SLOTS==0, the block enters INIT directly.
  - This provides the guarantee the bypass depends on: its records are not reset, so no write may occur for NUM_BYPASS_SLOTS cycles after reset.
- INIT
  - One write per cycle, addr 0,1,…,DEPTH-1, data INIT_VALUE.
  - The address counter saturates at DEPTH-1; the block moves to RUN after the write to DEPTH-1 is issued.
  - req_ready is all-zero.
- RUN
  - init_done=1.
  - Round-robin arbitration: the grant goes to the first valid requester at or after the priority pointer, wrapping modulo NUM_WRITERS.
  - req_ready[i]=1 only for the granted requester, and never while req_valid[i]=0.
  - A transfer occurs when req_valid[i]&&req_ready[i]. On a transfer, the pointer moves to (i+1) mod NUM_WRITERS; the pointer resets to 0.
  - With no valid requester, the pointer holds.
- Requester rule: after asserting req_valid, a requester holds req_valid, req_addr and req_data stable until the transfer.
- Out-of-range address (req_addr ≥ DEPTH): the request is accepted (ready asserted, the transfer counts for round-robin), wren_out stays 0 for that slot, and addr_error is set. addr_error clears only on reset.
- NUM_WRITERS==1: the grant is req_valid[0] in RUN.

## Timing

- Reset values (asynchronous, immediate on rst_n low):
  - wren_out=0, write_addr_out=0, write_data_out=0.
  - init_done=0, addr_error=0.
  - req_ready=0, priority pointer=0, state=FLUSH.
- Cycle numbering: cycle 1 is the first rising edge with rst_n high.
  - Cycles 1..NUM_BYPASS_SLOTS: wren_out=0.
  - Cycles NUM_BYPASS_SLOTS+1 .. NUM_BYPASS_SLOTS+DEPTH: wren_out=1, addr = cycle−NUM_BYPASS_SLOTS−1.
  - init_done rises at cycle NUM_BYPASS_SLOTS+DEPTH+1.
- Write latency: a transfer sampled at edge T drives wren_out/addr/data during the cycle after edge T, for exactly one cycle.
- Throughput: one write per cycle sustained, no bubbles between different requesters.
- Reset asserted mid-INIT or mid-RUN:
  - In-flight writes are lost, and the registered write is cancelled immediately.
  - After release, the full FLUSH+INIT sequence restarts from address 0.
- Requests arriving during FLUSH/INIT are not lost, because requesters hold them. They are serviced from the first RUN cycle, where the pointer starts at 0.

## Test plan

- Reset release, with DEPTH=8, NUM_BYPASS_SLOTS=2, INIT_VALUE=0xA5:
  - Required: wren_out=0 in cycles 1–2; writes to addr 0..7 with data 0xA5 in cycles 3–10; init_done=1 from cycle 11.
- Both writers hold valid continuously in RUN (w0 addr 1 data 0x11, w1 addr 2 data 0x22):
  - Required: grants alternate w0,w1,w0,w1 starting with w0; wren_out high every cycle, one cycle after each grant.
- Only w1 is valid, streaming addr 0..3 back-to-back:
  - Required: four consecutive writes with no gaps; req_ready[0] stays 0.
- w0 asserts valid (addr 5, data 0x55) during INIT:
  - Required: req_ready[0]=0 until the first RUN cycle, then the transfer occurs; the write to addr 5 appears the following cycle.
- DEPTH=6, w0 writes addr 7 then addr 3:
  - Required: no wren for addr 7, and addr_error=1 one cycle after that transfer; the addr 3 write does occur; addr_error stays 1 until reset.
- rst_n pulsed low while INIT is at addr 4:
  - Required: all outputs are 0 during reset without waiting for a clock edge; after release, the full flush then addr 0..DEPTH-1 sweep repeats.
